// File: rtl/lfsr_bank_sequencer.sv
// lfsr_bank_sequencer
//   Sequences a bank of NLFSR M-bit stochastic-number LFSRs. On start, each
//   LFSR is seeded in index order from a valid/ready seed stream (one-hot load
//   strobes plus a shared registered seed word). The bank then runs for a
//   programmed number of unpaused inference cycles. It is frozen (stoch_log)
//   while the downstream stochastic-logic stage requests a pause.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, abort        run request (accepted in IDLE) / synchronous abort
//   n_cycles [CW]       inference cycles to run, latched on accepted start
//   pause               hold request from the stochastic-logic stage
//   seed_valid/_data    seed stream in; seed_ready out (high in LOAD)
//   load_lfsr [NLFSR]   one-hot load strobe; seeds [M] registered seed word
//   inference           advance-the-bank enable
//   stoch_log           bank freeze (only in RUN while paused)
//   busy, done          not-IDLE flag, one-cycle completion pulse
//   cycle_cnt [CW]      effective inference cycles elapsed in the current run
module lfsr_bank_sequencer #(
  parameter int NLFSR = 4,
  parameter int M     = 8,
  parameter int CW    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CW-1:0]    n_cycles,
  input  logic             pause,
  input  logic             seed_valid,
  input  logic [M-1:0]     seed_data,
  output logic             seed_ready,
  output logic [NLFSR-1:0] load_lfsr,
  output logic [M-1:0]     seeds,
  output logic             inference,
  output logic             stoch_log,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    cycle_cnt
);

  localparam int IW = (NLFSR > 1) ? $clog2(NLFSR) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_lat_q, cnt_lat_d;
  logic [CW-1:0]     cycle_cnt_q, cycle_cnt_d;
  logic [M-1:0]      seeds_q, seeds_d;
  logic [NLFSR-1:0]  load_q, load_d;
  logic [CW-1:0]     cnt_inc;

  assign cnt_inc = cycle_cnt_q + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_lat_q   <= '0;
      cycle_cnt_q <= '0;
      seeds_q     <= '0;
      load_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_lat_q   <= cnt_lat_d;
      cycle_cnt_q <= cycle_cnt_d;
      seeds_q     <= seeds_d;
      load_q      <= load_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_lat_d   = cnt_lat_q;
    cycle_cnt_d = cycle_cnt_q;
    seeds_d     = seeds_q;
    // Load strobes are single-cycle: cleared unless a handshake re-arms them.
    load_d      = '0;

    // Abort outranks every other transition, including a same-cycle start or
    // seed handshake; counters and the seed word are left untouched.
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_lat_d   = n_cycles;
            cycle_cnt_d = '0;
            idx_d       = '0;
            state_d     = S_LOAD;
          end
        end
        S_LOAD: begin
          if (seed_valid) begin
            seeds_d = seed_data;
            load_d  = NLFSR'(1) << idx_q;
            idx_d   = idx_q + IW'(1);
            if (idx_q == IW'(NLFSR - 1)) begin
              state_d = S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          // Gives the final strobe its own cycle so it never overlaps inference.
          state_d = (cnt_lat_q != '0) ? S_RUN : S_DONE;
        end
        S_RUN: begin
          if (!pause) begin
            cycle_cnt_d = cnt_inc;
            if (cnt_inc == cnt_lat_q) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign seed_ready = (state_q == S_LOAD);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  // The only input-to-output paths: pause steers the run enable and freeze.
  assign inference  = (state_q == S_RUN) && !pause;
  assign stoch_log  = (state_q == S_RUN) && pause;
  assign load_lfsr  = load_q;
  assign seeds      = seeds_q;
  assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_lfsr_bank_sequencer.sv
module tb_lfsr_bank_sequencer;

  localparam int NL = 4;
  localparam int MW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] n_cycles = '0;
  logic          pause = 1'b0;
  logic          seed_valid = 1'b0;
  logic [MW-1:0] seed_data = '0;
  logic          seed_ready;
  logic [NL-1:0] load_lfsr;
  logic [MW-1:0] seeds;
  logic          inference;
  logic          stoch_log;
  logic          busy;
  logic          done;
  logic [CW-1:0] cycle_cnt;

  lfsr_bank_sequencer #(.NLFSR(NL), .M(MW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .n_cycles(n_cycles), .pause(pause), .seed_valid(seed_valid),
    .seed_data(seed_data), .seed_ready(seed_ready), .load_lfsr(load_lfsr),
    .seeds(seeds), .inference(inference), .stoch_log(stoch_log),
    .busy(busy), .done(done), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: what the run should look like, in terms of phase of the
  // job, how many seeds have been taken and how many cycles have elapsed.
  localparam int P_IDLE = 0, P_LOAD = 1, P_SETTLE = 2, P_RUN = 3, P_DONE = 4;
  int          m_ph, m_taken, m_target, m_elapsed;
  bit          m_strobe;
  logic [7:0]  m_seed;

  task automatic model_reset();
    m_ph = P_IDLE; m_taken = 0; m_target = 0; m_elapsed = 0;
    m_strobe = 0; m_seed = '0;
  endtask

  task automatic model_step(input bit st, input bit ab, input bit pa,
                            input bit sv, input logic [7:0] sd, input int nc);
    m_strobe = 0;
    if (ab) m_ph = P_IDLE;
    else begin
      case (m_ph)
        P_IDLE: if (st) begin
          m_target = nc; m_elapsed = 0; m_taken = 0; m_ph = P_LOAD;
        end
        P_LOAD: if (sv) begin
          m_seed = sd; m_taken++; m_strobe = 1;
          if (m_taken == NL) m_ph = P_SETTLE;
        end
        P_SETTLE: m_ph = (m_target == 0) ? P_DONE : P_RUN;
        P_RUN: if (!pa) begin
          m_elapsed++;
          if (m_elapsed == m_target) m_ph = P_DONE;
        end
        default: m_ph = P_IDLE;
      endcase
    end
  endtask

  task automatic check_outputs(input bit pa);
    logic [NL-1:0] exp_load;
    exp_load = m_strobe ? NL'(1 << (m_taken - 1)) : '0;
    chk("load_lfsr",  load_lfsr,  exp_load);
    chk("seeds",      seeds,      m_seed);
    chk("seed_ready", seed_ready, m_ph == P_LOAD);
    chk("busy",       busy,       m_ph != P_IDLE);
    chk("done",       done,       m_ph == P_DONE);
    chk("inference",  inference,  (m_ph == P_RUN) && !pa);
    chk("stoch_log",  stoch_log,  (m_ph == P_RUN) && pa);
    chk("cycle_cnt",  cycle_cnt,  m_elapsed);
  endtask

  // Per-job observations.
  logic [7:0] obs_seeds[$];
  int inf_cnt, paused_cnt, done_cnt, done_cyc, cyc;
  logic [7:0] job_seeds [NL];

  // Called just after a falling edge: drive, check this cycle, advance model.
  task automatic step(input bit st, input bit ab, input bit pa, input bit sv,
                      input logic [7:0] sd, input int nc);
    start = st; abort = ab; pause = pa; seed_valid = sv; seed_data = sd;
    n_cycles = CW'(nc);
    #1;
    check_outputs(pa);
    if (load_lfsr != '0) obs_seeds.push_back(seeds);
    if (inference) inf_cnt++;
    if (stoch_log) paused_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    cyc++;
    model_step(st, ab, pa, sv, sd, nc);
    @(negedge clk);
  endtask

  // gap <0: random seed_valid; pf/pl: forced pause window (cycles since start);
  // abort_at / reset_at: cycle index for abort / async reset (-1 = none).
  task automatic run_job(input int n, input int gap, input int pause_pct,
                         input int pf, input int pl, input int abort_at,
                         input int reset_at, input int exp_done, input int exp_paused);
    int k, gcnt, budget;
    bit sv, pa, ab, aborted, was_reset;
    logic [7:0] sd;
    obs_seeds.delete();
    inf_cnt = 0; paused_cnt = 0; done_cnt = 0; done_cyc = -1; cyc = 0;
    k = 0; gcnt = 0; aborted = (abort_at == 0); was_reset = 0;
    budget = 2 * n + pl + 400;
    step(1'b1, abort_at == 0, 1'b0, 1'b0, 8'($urandom), n);
    for (int c = 1; c < budget; c++) begin
      if (m_ph == P_IDLE) break;
      if (gap < 0) sv = ($urandom_range(1) == 1);
      else sv = (gcnt == 0);
      if (k >= NL) sv = ($urandom_range(1) == 1);
      sd = (sv && k < NL) ? job_seeds[k] : 8'($urandom);
      pa = ((c >= pf) && (c < pf + pl)) || (int'($urandom_range(99)) < pause_pct);
      ab = (c == abort_at);
      if (ab) aborted = 1;
      if (m_ph == P_LOAD && sv && !ab) begin
        k++; gcnt = (gap > 0) ? gap : 0;
      end else if (gcnt > 0 && m_ph == P_LOAD) gcnt--;
      step(1'($urandom_range(1)), ab, pa, sv, sd, $urandom_range(65535));
      if (c == reset_at) begin
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(pa);
        @(negedge clk);
        rst_n = 1'b1;
        was_reset = 1;
        break;
      end
    end
    chk("job_ends_idle", busy, 1'b0);
    if (aborted || was_reset) begin
      chk("no_done_on_abort", done_cnt, 0);
    end else begin
      chk("done_pulses", done_cnt, 1);
      chk("inference_total", inf_cnt, n);
      chk("final_cycle_cnt", cycle_cnt, n);
      chk("strobe_count", obs_seeds.size(), NL);
      for (int i = 0; i < NL && i < obs_seeds.size(); i++)
        chk($sformatf("seed_order[%0d]", i), obs_seeds[i], job_seeds[i]);
      if (exp_done >= 0) chk("done_cycle", done_cyc, exp_done);
      if (exp_paused >= 0) chk("paused_cycles", paused_cnt, exp_paused);
    end
    // Idle gap so that ignored inputs in IDLE are also exercised.
    step(1'b0, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom), 0);
  endtask

  task automatic set_fixed_seeds();
    job_seeds[0] = 8'hA5; job_seeds[1] = 8'h3C;
    job_seeds[2] = 8'h81; job_seeds[3] = 8'hFF;
  endtask

  task automatic set_random_seeds();
    for (int i = 0; i < NL; i++) job_seeds[i] = 8'($urandom);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_outputs(1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back seeds, 5 cycles: done 6+n cycles after start.
    set_fixed_seeds();
    run_job(5, 0, 0, -1, 0, -1, -1, 11, 0);
    // Gapped seed stream.
    set_random_seeds();
    run_job(3, 2, 0, -1, 0, -1, -1, -1, 0);
    // Zero cycles: SETTLE then DONE, no inference.
    set_random_seeds();
    run_job(0, 0, 0, -1, 0, -1, -1, 6, 0);
    // Three-cycle pause mid-run pushes done 3 cycles later.
    set_random_seeds();
    run_job(6, 0, 0, 8, 3, -1, -1, 15, 3);
    // Abort after two seeds, then abort in RUN at cycle_cnt==3, then a clean run.
    set_random_seeds();
    run_job(6, 0, 0, -1, 0, 3, -1, -1, -1);
    set_random_seeds();
    run_job(6, 0, 0, -1, 0, 9, -1, -1, -1);
    set_fixed_seeds();
    run_job(5, 0, 0, -1, 0, -1, -1, 11, 0);
    // Simultaneous start+abort in IDLE drops the start.
    run_job(4, 0, 0, -1, 0, 0, -1, -1, -1);
    // Asynchronous reset mid-run, then the first scenario again.
    set_random_seeds();
    run_job(8, 0, 0, -1, 0, -1, 8, -1, -1);
    set_fixed_seeds();
    run_job(5, 0, 0, -1, 0, -1, -1, 11, 0);
    // Randomized jobs.
    for (int j = 0; j < 16; j++) begin
      set_random_seeds();
      run_job($urandom_range(12), -1, 30, -1, 0,
              ($urandom_range(4) == 0) ? int'($urandom_range(25)) : -1,
              -1, -1, -1);
    end
    // Full-width count runs without wrap.
    set_random_seeds();
    run_job(65535, 0, 0, -1, 0, -1, -1, 6 + 65535, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
